// File: rtl/trig_pkg.sv
// Shared types and helpers for the multi-channel burst trigger generator.
//   chan_state_e : per-channel FSM state
//   ws_t/eff_ws  : effective pulse width W and period S from raw fields
package trig_pkg;
  localparam int CH_NUM_DEF = 17;
  localparam int CNT_W_DEF  = 32;
  localparam int PW_W_DEF   = 8;

  typedef enum logic [1:0] {ST_IDLE, ST_DLY, ST_HIGH, ST_GAP} chan_state_e;

  typedef struct packed {
    logic [CNT_W_DEF-1:0] w;
    logic [CNT_W_DEF-1:0] s;
  } ws_t;

  // W = max(pw,1); S = max(step, W+1) so every pulse is followed by a low clock.
  function automatic ws_t eff_ws(input logic [CNT_W_DEF-1:0] pw,
                                 input logic [CNT_W_DEF-1:0] step);
    ws_t r;
    r.w = (pw == '0) ? CNT_W_DEF'(1) : pw;
    r.s = (step <= r.w) ? r.w + CNT_W_DEF'(1) : step;
    return r;
  endfunction
endpackage

// File: rtl/trig_burst_chan.sv
// One trigger channel: IDLE -> DLY -> HIGH -> GAP -> HIGH ... -> IDLE.
//   start    : accepted start with this channel enabled (enters DLY/HIGH)
//   clear    : any accepted start; zeroes the pulse counter
//   abort    : forces IDLE on the next edge
//   delay    : live delay (only sampled with start)
//   w/gap    : high and low phase lengths in clocks (both >= 1)
//   num/cont : pulses per burst / free-running mode
//   trig     : registered trigger output
//   active_d : next-state is not IDLE (feeds the top's Busy/Done flops)
//   pcnt     : rising edges issued since the last clear
module trig_burst_chan
  import trig_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  input  logic             abort,
  input  logic [CNT_W-1:0] delay,
  input  logic [CNT_W-1:0] w,
  input  logic [CNT_W-1:0] gap,
  input  logic [CNT_W-1:0] num,
  input  logic             cont,
  output logic             trig,
  output logic             active_d,
  output logic [CNT_W-1:0] pcnt
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;    // clocks left in the current phase, minus one
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic             trig_q, trig_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else if (clear) begin
      pcnt_d = '0;
      if (start) begin
        if (delay == '0) begin
          state_d = ST_HIGH;
          cnt_d   = w - ONE;
          pcnt_d  = ONE;
        end else begin
          state_d = ST_DLY;
          cnt_d   = delay - ONE;
        end
      end
    end else begin
      // Down-counters only step while non-zero, so they can never wrap.
      case (state_q)
        ST_DLY, ST_GAP: begin
          if (cnt_q == '0) begin
            state_d = ST_HIGH;
            cnt_d   = w - ONE;
            pcnt_d  = pcnt_q + ONE;  // wraps freely in continuous mode
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        ST_HIGH: begin
          if (cnt_q == '0) begin
            // pcnt already counts the pulse being finished: no trailing gap.
            if (!cont && pcnt_q == num) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_GAP;
              cnt_d   = gap - ONE;
            end
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        default: ;
      endcase
    end
    trig_d   = (state_d == ST_HIGH);
    active_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      trig_q  <= trig_d;
    end
  end

  assign trig = trig_q;
  assign pcnt = pcnt_q;
endmodule

// File: rtl/trig_burst_gen_mc.sv
// Multi-channel burst trigger generator. One accepted start launches a burst
// on every enabled channel, each after its own delay.
//   I_clk/I_Rst   : trigger clock, async active-high reset
//   I_Trig_in     : start request (rising edge), I_Abort: sync abort
//   I_Ch_En, I_Trig_Num, I_Trig_Step, I_Delay, I_Pulse_Width, I_Continuous:
//                   burst configuration, latched at start acceptance
//   O_Trig        : registered trigger lines
//   O_Busy/O_Done : burst in progress / one-cycle completion pulse
//   O_Pulse_Cnt   : pulses issued by the lowest enabled channel
module trig_burst_gen_mc
  import trig_pkg::*;
#(
  parameter int CH_NUM = CH_NUM_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int PW_W   = PW_W_DEF
) (
  input  logic                    I_clk,
  input  logic                    I_Rst,
  input  logic                    I_Trig_in,
  input  logic                    I_Abort,
  input  logic [CH_NUM-1:0]       I_Ch_En,
  input  logic [CNT_W-1:0]        I_Trig_Num,
  input  logic [CNT_W-1:0]        I_Trig_Step,
  input  logic [CH_NUM*CNT_W-1:0] I_Delay,
  input  logic [PW_W-1:0]         I_Pulse_Width,
  input  logic                    I_Continuous,
  output logic [CH_NUM-1:0]       O_Trig,
  output logic                    O_Busy,
  output logic                    O_Done,
  output logic [CNT_W-1:0]        O_Pulse_Cnt
);
  localparam int IDX_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  logic                         trig_in_q, busy_q, busy_d, done_q, done_d;
  logic [CNT_W-1:0]             w_q, w_d, gap_q, gap_d, num_q, num_d;
  logic                         cont_q, cont_d;
  logic [IDX_W-1:0]             ref_q, ref_d;
  ws_t                          ws;
  logic [CNT_W-1:0]             w_in, s_in, w_use;
  logic                         accept, run_ok;
  logic [CH_NUM-1:0]            chan_start, chan_active_d, chan_trig;
  logic [CH_NUM-1:0][CNT_W-1:0] chan_pcnt;

  // Abort beats a simultaneous start; starts while busy are simply dropped.
  assign accept     = I_Trig_in & ~trig_in_q & ~busy_q & ~I_Abort;
  assign run_ok     = (|I_Ch_En) & (I_Continuous | (|I_Trig_Num));
  assign chan_start = {CH_NUM{accept & run_ok}} & I_Ch_En;

  assign ws    = eff_ws(CNT_W_DEF'(I_Pulse_Width), CNT_W_DEF'(I_Trig_Step));
  assign w_in  = CNT_W'(ws.w);
  assign s_in  = CNT_W'(ws.s);
  // A zero-delay channel enters HIGH on the accept edge, before w_q is loaded.
  assign w_use = accept ? w_in : w_q;

  always_comb begin
    w_d    = w_q;
    gap_d  = gap_q;
    num_d  = num_q;
    cont_d = cont_q;
    ref_d  = ref_q;
    if (accept) begin
      w_d    = w_in;
      gap_d  = s_in - w_in;
      num_d  = I_Trig_Num;
      cont_d = I_Continuous;
      ref_d  = '0;
      for (int k = CH_NUM - 1; k >= 0; k--)
        if (I_Ch_En[k]) ref_d = IDX_W'(k);
    end
    busy_d = |chan_active_d;
    // Degenerate starts complete immediately; aborts never report done.
    done_d = ~I_Abort & ((accept & ~run_ok) | (busy_q & ~busy_d));
  end

  always_ff @(posedge I_clk or posedge I_Rst) begin
    if (I_Rst) begin
      trig_in_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      w_q       <= '0;
      gap_q     <= '0;
      num_q     <= '0;
      cont_q    <= 1'b0;
      ref_q     <= '0;
    end else begin
      trig_in_q <= I_Trig_in;
      busy_q    <= busy_d;
      done_q    <= done_d;
      w_q       <= w_d;
      gap_q     <= gap_d;
      num_q     <= num_d;
      cont_q    <= cont_d;
      ref_q     <= ref_d;
    end
  end

  for (genvar k = 0; k < CH_NUM; k++) begin : g_chan
    trig_burst_chan #(.CNT_W(CNT_W)) u_chan (
      .clk      (I_clk),
      .rst      (I_Rst),
      .start    (chan_start[k]),
      .clear    (accept),
      .abort    (I_Abort),
      .delay    (I_Delay[k*CNT_W +: CNT_W]),
      .w        (w_use),
      .gap      (gap_q),
      .num      (num_q),
      .cont     (cont_q),
      .trig     (chan_trig[k]),
      .active_d (chan_active_d[k]),
      .pcnt     (chan_pcnt[k])
    );
  end

  assign O_Trig      = chan_trig;
  assign O_Busy      = busy_q;
  assign O_Done      = done_q;
  assign O_Pulse_Cnt = chan_pcnt[ref_q];
endmodule

// File: tb/tb_trig_burst_gen_mc.sv
module tb_trig_burst_gen_mc;
  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          I_Rst, I_Trig_in, I_Abort, I_Continuous;
  logic [CH-1:0] I_Ch_En;
  logic [31:0]   I_Trig_Num, I_Trig_Step;
  logic [CH*32-1:0] I_Delay;
  logic [7:0]    I_Pulse_Width;
  logic [CH-1:0] O_Trig;
  logic          O_Busy, O_Done;
  logic [31:0]   O_Pulse_Cnt;
  logic [37:0]   obs, exp_v;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] last_cnt;

  // burst description used by both the stimulus and the reference model
  logic [3:0] m_en;
  int m_d[4];
  int m_num, m_step, m_pw;
  bit m_cont;

  trig_burst_gen_mc #(.CH_NUM(CH), .CNT_W(32), .PW_W(8)) dut (
    .I_clk(clk), .I_Rst(I_Rst), .I_Trig_in(I_Trig_in), .I_Abort(I_Abort),
    .I_Ch_En(I_Ch_En), .I_Trig_Num(I_Trig_Num), .I_Trig_Step(I_Trig_Step),
    .I_Delay(I_Delay), .I_Pulse_Width(I_Pulse_Width), .I_Continuous(I_Continuous),
    .O_Trig(O_Trig), .O_Busy(O_Busy), .O_Done(O_Done), .O_Pulse_Cnt(O_Pulse_Cnt));

  always #5 clk = ~clk;
  assign obs = {O_Trig, O_Busy, O_Done, O_Pulse_Cnt};

  // Expected {trig, busy, done, pulse_cnt} in cycle c, with the start accepted in cycle 0.
  function automatic logic [37:0] model(input int c);
    int w, s, last, off, refk;
    logic [3:0] tr;
    logic bz, dn;
    logic [31:0] pc;
    bit run;
    w = (m_pw == 0) ? 1 : m_pw;
    s = (m_step < w + 1) ? w + 1 : m_step;
    run = (m_en != 4'd0) && (m_cont || m_num != 0);
    tr = '0; last = 0; refk = -1; pc = '0;
    for (int k = 0; k < 4; k++) begin
      if (run && m_en[k]) begin
        if (refk < 0) refk = k;
        if (!m_cont && m_d[k] + w + (m_num - 1) * s > last) last = m_d[k] + w + (m_num - 1) * s;
        off = c - 1 - m_d[k];
        if (off >= 0 && (off % s) < w && (m_cont || off / s < m_num)) tr[k] = 1'b1;
      end
    end
    bz = run && c >= 1 && (m_cont || c <= last);
    dn = !m_cont && (run ? (c == last + 1) : (c == 1));
    if (run) begin
      off = c - 1 - m_d[refk];
      if (off >= 0) pc = (m_cont || off / s + 1 < m_num) ? 32'(off / s + 1) : 32'(m_num);
    end
    return {tr, bz, dn, pc};
  endfunction

  task automatic start_burst();
    @(negedge clk);
    I_Ch_En = m_en;
    I_Trig_Num = 32'(m_num);
    I_Trig_Step = 32'(m_step);
    I_Pulse_Width = 8'(m_pw);
    I_Continuous = m_cont;
    for (int k = 0; k < 4; k++) I_Delay[k*32 +: 32] = 32'(m_d[k]);
    I_Trig_in = 1'b1;
  endtask

  task automatic set_cfg(input logic [3:0] en, input int d0, input int d1, input int d2,
                         input int d3, input int num, input int step, input int pw, input bit cont);
    m_en = en; m_d[0] = d0; m_d[1] = d1; m_d[2] = d2; m_d[3] = d3;
    m_num = num; m_step = step; m_pw = pw; m_cont = cont;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== 38'd0) begin
        n_err++;
        $display("FAIL reset: outputs got %h want 0", obs);
      end
    end
    I_Rst = 1'b0;
    last_cnt = '0;
  endtask

  task automatic test_single();
    set_cfg(4'b0001, 0, 0, 0, 0, 3, 10, 2, 1'b0);
    start_burst();
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) I_Trig_in = 1'b0;
      exp_v = model(c);
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL single c=%0d got %h want %h", c, obs, exp_v);
      end
    end
    last_cnt = exp_v[31:0];
  endtask

  task automatic test_delays();
    set_cfg(4'b1111, 0, 5, 17, 1000, 2, 4, 1, 1'b0);
    start_burst();
    for (int c = 1; c <= 1010; c++) begin
      @(negedge clk);
      if (c == 1) I_Trig_in = 1'b0;
      exp_v = model(c);
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL delays c=%0d got %h want %h", c, obs, exp_v);
      end
    end
    last_cnt = exp_v[31:0];
  endtask

  task automatic test_clamp();
    set_cfg(4'b0011, 0, 3, 0, 0, 4, 0, 0, 1'b0);
    start_burst();
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 1) I_Trig_in = 1'b0;
      exp_v = model(c);
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL clamp c=%0d got %h want %h", c, obs, exp_v);
      end
    end
    last_cnt = exp_v[31:0];
  endtask

  task automatic test_degenerate();
    for (int v = 0; v < 2; v++) begin
      if (v == 0) set_cfg(4'b1111, 0, 1, 2, 3, 0, 5, 2, 1'b0);
      else        set_cfg(4'b0000, 0, 1, 2, 3, 3, 5, 2, 1'b0);
      start_burst();
      for (int c = 1; c <= 6; c++) begin
        @(negedge clk);
        if (c == 1) I_Trig_in = 1'b0;
        exp_v = model(c);
        n_cmp++;
        if (obs !== exp_v) begin
          n_err++;
          $display("FAIL degenerate%0d c=%0d got %h want %h", v, c, obs, exp_v);
        end
      end
      last_cnt = exp_v[31:0];
    end
  endtask

  task automatic test_back_to_back();
    set_cfg(4'b0011, 0, 3, 0, 0, 3, 6, 2, 1'b0);
    start_burst();
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) I_Trig_in = 1'b0;
      if (c == 4) begin
        I_Trig_in = 1'b1;
        I_Trig_Num = 32'd9;
        I_Trig_Step = 32'd3;
        I_Pulse_Width = 8'd1;
        I_Delay = '0;
        I_Ch_En = 4'hF;
      end
      exp_v = model(c);
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL back_to_back c=%0d got %h want %h", c, obs, exp_v);
      end
    end
    I_Trig_in = 1'b0;
    last_cnt = exp_v[31:0];
  endtask

  task automatic test_hold();
    set_cfg(4'b0001, 0, 0, 0, 0, 1, 2, 1, 1'b0);
    start_burst();
    for (int c = 1; c <= 55; c++) begin
      @(negedge clk);
      if (c == 50) I_Trig_in = 1'b0;
      exp_v = model(c);
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL hold c=%0d got %h want %h", c, obs, exp_v);
      end
    end
    last_cnt = exp_v[31:0];
  endtask

  task automatic test_continuous();
    int edges;
    logic prev;
    edges = 0; prev = 1'b0;
    set_cfg(4'b0101, 0, 0, 3, 0, 0, 8, 3, 1'b1);
    start_burst();
    for (int c = 1; c <= 1000; c++) begin
      @(negedge clk);
      if (c == 1) I_Trig_in = 1'b0;
      if (O_Trig[0] && !prev) edges++;
      prev = O_Trig[0];
      exp_v = model(c);
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL continuous c=%0d got %h want %h", c, obs, exp_v);
      end
    end
    n_cmp++;
    if (edges !== 125) begin
      n_err++;
      $display("FAIL continuous_edges got %0d want 125", edges);
    end
    I_Abort = 1'b1;
    for (int c = 1001; c <= 1005; c++) begin
      @(negedge clk);
      I_Abort = 1'b0;
      n_cmp++;
      if (obs !== {6'd0, 32'd125}) begin
        n_err++;
        $display("FAIL abort c=%0d got %h want %h", c, obs, {6'd0, 32'd125});
      end
    end
    last_cnt = 32'd125;
  endtask

  task automatic test_start_abort();
    set_cfg(4'b1111, 0, 0, 0, 0, 3, 4, 1, 1'b0);
    start_burst();
    I_Abort = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      I_Trig_in = 1'b0;
      I_Abort = 1'b0;
      n_cmp++;
      if (obs !== {6'd0, last_cnt}) begin
        n_err++;
        $display("FAIL start_abort c=%0d got %h want %h", c, obs, {6'd0, last_cnt});
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      set_cfg(4'($urandom_range(0, 15)), $urandom_range(0, 20), $urandom_range(0, 20),
              $urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 5),
              $urandom_range(0, 12), $urandom_range(0, 5), 1'b0);
      start_burst();
      for (int c = 1; c <= 120; c++) begin
        @(negedge clk);
        if (c == 1) I_Trig_in = 1'b0;
        exp_v = model(c);
        n_cmp++;
        if (obs !== exp_v) begin
          n_err++;
          $display("FAIL random%0d c=%0d got %h want %h", it, c, obs, exp_v);
        end
      end
      last_cnt = exp_v[31:0];
    end
  endtask

  task automatic test_async_reset();
    set_cfg(4'b0001, 0, 0, 0, 0, 3, 10, 2, 1'b0);
    start_burst();
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      if (c == 1) I_Trig_in = 1'b0;
      exp_v = model(c);
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL pre_reset c=%0d got %h want %h", c, obs, exp_v);
      end
    end
    #2 I_Rst = 1'b1;
    #1;
    n_cmp++;
    if (obs !== 38'd0) begin
      n_err++;
      $display("FAIL async_reset got %h want 0", obs);
    end
    @(negedge clk);
    I_Rst = 1'b0;
    last_cnt = '0;
    test_single();
  endtask

  initial begin
    I_Rst = 1'b1; I_Trig_in = 1'b0; I_Abort = 1'b0; I_Continuous = 1'b0;
    I_Ch_En = '0; I_Trig_Num = '0; I_Trig_Step = '0; I_Delay = '0; I_Pulse_Width = '0;
    last_cnt = '0;
    test_reset();
    test_single();
    test_delays();
    test_clamp();
    test_degenerate();
    test_back_to_back();
    test_hold();
    test_continuous();
    test_start_abort();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
